// File: rtl/reg_writeback_if.sv
// Producer, issue and register-file signals of the writeback stage.
interface reg_writeback_if;
  logic        issue_valid;
  logic [2:0]  issue_addr;
  logic [2:0]  chk_addr1;
  logic [2:0]  chk_addr2;
  logic        hazard;
  logic [7:0]  busy;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_addr;
  logic [31:0] alu_value;
  logic        id_valid;
  logic        id_ready;
  logic [2:0]  id_addr;
  logic [31:0] id_value;
  logic [2:0]  write_addr;
  logic [31:0] write_value_alu;
  logic [31:0] write_value_id;
  logic        write_data_sel;
  logic        write_enable;

  modport master (
    output issue_valid, issue_addr, chk_addr1, chk_addr2,
    output alu_valid, alu_addr, alu_value, id_valid, id_addr, id_value,
    input  hazard, busy, alu_ready, id_ready,
    input  write_addr, write_value_alu, write_value_id, write_data_sel, write_enable
  );

  modport slave (
    input  issue_valid, issue_addr, chk_addr1, chk_addr2,
    input  alu_valid, alu_addr, alu_value, id_valid, id_addr, id_value,
    output hazard, busy, alu_ready, id_ready,
    output write_addr, write_value_alu, write_value_id, write_data_sel, write_enable
  );
endinterface

// File: rtl/reg_writeback.sv
// Queues ALU/ID results and drains one register-file write per cycle, plus a pending-write scoreboard.
// Write strobe rises the cycle after acceptance; readiness comes from the registered count only (ALU first).
module reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_writeback_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]    r_mem_addr  [DEPTH];
  logic [31:0]   r_mem_value [DEPTH];
  logic          r_mem_sel   [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_write_addr;
  logic [31:0]   r_write_value_alu;
  logic [31:0]   r_write_value_id;
  logic          r_write_data_sel;
  logic          r_write_enable;
  logic [7:0]    r_busy;

  logic [CW-1:0] w_free;
  logic          w_alu_push;
  logic          w_id_push;
  logic          w_pop;
  logic [AW-1:0] w_id_slot;
  logic [CW-1:0] w_count_next;
  logic [7:0]    w_busy_next;

  // A pop this cycle never frees space for a push in the same cycle.
  assign w_free        = CW'(DEPTH) - r_count;
  assign bus.alu_ready = (w_free >= CW'(1));
  assign bus.id_ready  = (w_free >= CW'(2)) | ((w_free >= CW'(1)) & ~bus.alu_valid);

  assign w_alu_push   = bus.alu_valid & bus.alu_ready;
  assign w_id_push    = bus.id_valid & bus.id_ready;
  assign w_pop        = (r_count != '0);
  assign w_id_slot    = r_wr_ptr + AW'(w_alu_push);
  assign w_count_next = r_count + CW'(w_alu_push) + CW'(w_id_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_alu_push) begin
      r_mem_addr[r_wr_ptr]  <= bus.alu_addr;
      r_mem_value[r_wr_ptr] <= bus.alu_value;
      r_mem_sel[r_wr_ptr]   <= 1'b1;
    end
    if (w_id_push) begin
      r_mem_addr[w_id_slot]  <= bus.id_addr;
      r_mem_value[w_id_slot] <= bus.id_value;
      r_mem_sel[w_id_slot]   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_alu_push) + AW'(w_id_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= w_count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_addr      <= '0;
      r_write_value_alu <= '0;
      r_write_value_id  <= '0;
      r_write_data_sel  <= 1'b0;
      r_write_enable    <= 1'b0;
    end else if (w_pop) begin
      r_write_addr      <= r_mem_addr[r_rd_ptr];
      r_write_data_sel  <= r_mem_sel[r_rd_ptr];
      r_write_value_alu <= r_mem_sel[r_rd_ptr] ? r_mem_value[r_rd_ptr] : 32'd0;
      r_write_value_id  <= r_mem_sel[r_rd_ptr] ? 32'd0 : r_mem_value[r_rd_ptr];
      r_write_enable    <= 1'b1;
    end else begin
      r_write_enable    <= 1'b0;
    end
  end

  // Set after clear: a fresh reservation outlives the write retiring this edge.
  always_comb begin
    w_busy_next = r_busy;
    if (r_write_enable) w_busy_next[r_write_addr] = 1'b0;
    if (bus.issue_valid) w_busy_next[bus.issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_next;
  end

  assign bus.hazard          = r_busy[bus.chk_addr1] | r_busy[bus.chk_addr2];
  assign bus.busy            = r_busy;
  assign bus.write_addr      = r_write_addr;
  assign bus.write_value_alu = r_write_value_alu;
  assign bus.write_value_id  = r_write_value_id;
  assign bus.write_data_sel  = r_write_data_sel;
  assign bus.write_enable    = r_write_enable;
endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_reg_writeback;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_writeback_if bus ();
  reg_writeback #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] value;
    logic        sel;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [2:0]  m_waddr;
  logic [31:0] m_valu;
  logic [31:0] m_vid;
  logic        m_sel;
  logic [7:0]  m_busy;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic exp_alu_rdy();
    return q.size() < DEPTH;
  endfunction

  function automatic logic exp_id_rdy();
    int fr;
    fr = DEPTH - q.size();
    return (fr >= 2) || (fr >= 1 && !bus.alu_valid);
  endfunction

  task automatic model_reset();
    q.delete();
    m_we = 0; m_waddr = 0; m_valu = 0; m_vid = 0; m_sel = 0; m_busy = 0;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_clock();
    bit   acc_a, acc_i;
    ent_t e;
    acc_a = bus.alu_valid && exp_alu_rdy();
    acc_i = bus.id_valid && exp_id_rdy();
    if (m_we) m_busy[m_waddr] = 1'b0;
    if (bus.issue_valid) m_busy[bus.issue_addr] = 1'b1;
    if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1; m_waddr = e.addr; m_sel = e.sel;
      m_valu = e.sel ? e.value : 32'd0;
      m_vid  = e.sel ? 32'd0 : e.value;
    end else begin
      m_we = 0;
    end
    if (acc_a) q.push_back('{bus.alu_addr, bus.alu_value, 1'b1});
    if (acc_i) q.push_back('{bus.id_addr, bus.id_value, 1'b0});
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 0; bus.issue_addr = 0; bus.chk_addr1 = 0; bus.chk_addr2 = 0;
    bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_value = 0;
    bus.id_valid = 0; bus.id_addr = 0; bus.id_value = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    #12;
    n_cmp++;
    if ({bus.write_enable, bus.write_addr, bus.write_data_sel} !== 5'd0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 00000", {bus.write_enable, bus.write_addr, bus.write_data_sel});
    end
    n_cmp++;
    if ({bus.write_value_alu, bus.write_value_id, bus.busy} !== 72'd0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {bus.write_value_alu, bus.write_value_id, bus.busy});
    end
    n_cmp++;
    if ({bus.alu_ready, bus.id_ready} !== 2'b11) begin
      n_err++; $display("FAIL reset_ready: got %b want 11", {bus.alu_ready, bus.id_ready});
    end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_single_alu();
    bus.alu_valid = 1; bus.alu_addr = 3; bus.alu_value = 32'hDEADBEEF;
    bus.issue_valid = 1; bus.issue_addr = 3;
    #1;
    n_cmp++;
    if (bus.alu_ready !== 1'b1) begin
      n_err++; $display("FAIL single_rdy: got %b want 1", bus.alu_ready);
    end
    tick();
    idle_inputs();
    n_cmp++;
    if ({bus.write_enable, bus.busy[3]} !== 2'b01) begin
      n_err++; $display("FAIL single_e0: we/busy3 got %b want 01", {bus.write_enable, bus.busy[3]});
    end
    tick();
    n_cmp++;
    if ({bus.write_enable, bus.write_addr, bus.write_data_sel, bus.write_value_alu, bus.write_value_id, bus.busy[3]}
        !== {1'b1, 3'd3, 1'b1, 32'hDEADBEEF, 32'd0, 1'b1}) begin
      n_err++; $display("FAIL single_write: got we=%b a=%0d sel=%b alu=%h id=%h busy3=%b want 1 3 1 deadbeef 0 1",
                        bus.write_enable, bus.write_addr, bus.write_data_sel, bus.write_value_alu, bus.write_value_id, bus.busy[3]);
    end
    tick();
    n_cmp++;
    if ({bus.write_enable, bus.busy[3]} !== 2'b00) begin
      n_err++; $display("FAIL single_e2: we/busy3 got %b want 00", {bus.write_enable, bus.busy[3]});
    end
  endtask

  task automatic test_dual();
    bus.alu_valid = 1; bus.alu_addr = 1; bus.alu_value = 32'h11;
    bus.id_valid = 1; bus.id_addr = 2; bus.id_value = 32'h22;
    #1;
    n_cmp++;
    if ({bus.alu_ready, bus.id_ready} !== 2'b11) begin
      n_err++; $display("FAIL dual_rdy: got %b want 11", {bus.alu_ready, bus.id_ready});
    end
    tick();
    idle_inputs();
    tick();
    n_cmp++;
    if ({bus.write_enable, bus.write_addr, bus.write_data_sel, bus.write_value_alu} !== {1'b1, 3'd1, 1'b1, 32'h11}) begin
      n_err++; $display("FAIL dual_first: got we=%b a=%0d sel=%b alu=%h want 1 1 1 11",
                        bus.write_enable, bus.write_addr, bus.write_data_sel, bus.write_value_alu);
    end
    tick();
    n_cmp++;
    if ({bus.write_enable, bus.write_addr, bus.write_data_sel, bus.write_value_id, bus.write_value_alu}
        !== {1'b1, 3'd2, 1'b0, 32'h22, 32'd0}) begin
      n_err++; $display("FAIL dual_second: got we=%b a=%0d sel=%b id=%h alu=%h want 1 2 0 22 0",
                        bus.write_enable, bus.write_addr, bus.write_data_sel, bus.write_value_id, bus.write_value_alu);
    end
    tick();
    n_cmp++;
    if (bus.write_enable !== 1'b0) begin
      n_err++; $display("FAIL dual_idle: we got %b want 0", bus.write_enable);
    end
  endtask

  // Both producers held valid: after two cycles the queue holds three entries and only the ALU gets in.
  task automatic test_back_to_back();
    for (int c = 0; c < 10; c++) begin
      bus.alu_valid = 1; bus.alu_addr = 3'($urandom); bus.alu_value = $urandom;
      bus.id_valid  = (c != 9); bus.id_addr = 3'($urandom); bus.id_value = $urandom;
      #1;
      n_cmp++;
      if ({bus.alu_ready, bus.id_ready} !== ((c < 2) ? 2'b11 : 2'b10)) begin
        n_err++; $display("FAIL b2b_rdy[%0d]: got %b want %b", c, {bus.alu_ready, bus.id_ready}, (c < 2) ? 2'b11 : 2'b10);
      end
      tick();
      n_cmp++;
      if ({bus.write_enable, bus.write_addr, bus.write_data_sel, bus.write_value_alu, bus.write_value_id}
          !== {m_we, m_waddr, m_sel, m_valu, m_vid}) begin
        n_err++; $display("FAIL b2b_out[%0d]: got %b %0d %b %h %h want %b %0d %b %h %h", c,
                          bus.write_enable, bus.write_addr, bus.write_data_sel, bus.write_value_alu, bus.write_value_id,
                          m_we, m_waddr, m_sel, m_valu, m_vid);
      end
    end
    bus.alu_valid = 0; bus.id_valid = 1; bus.id_addr = 7; bus.id_value = 32'h77;
    #1;
    n_cmp++;
    if ({bus.alu_ready, bus.id_ready} !== 2'b11) begin
      n_err++; $display("FAIL b2b_id_space: got %b want 11", {bus.alu_ready, bus.id_ready});
    end
    tick();
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if ({bus.write_enable, bus.write_addr, bus.write_data_sel, bus.write_value_alu, bus.write_value_id}
          !== {m_we, m_waddr, m_sel, m_valu, m_vid}) begin
        n_err++; $display("FAIL b2b_drain[%0d]: got %b %0d %b %h %h want %b %0d %b %h %h", c,
                          bus.write_enable, bus.write_addr, bus.write_data_sel, bus.write_value_alu, bus.write_value_id,
                          m_we, m_waddr, m_sel, m_valu, m_vid);
      end
    end
  endtask

  task automatic test_issue_hazard();
    bus.alu_valid = 1; bus.alu_addr = 5; bus.alu_value = 32'h55;
    bus.issue_valid = 1; bus.issue_addr = 5;
    tick();
    idle_inputs();
    tick();
    n_cmp++;
    if ({bus.write_enable, bus.write_addr} !== {1'b1, 3'd5}) begin
      n_err++; $display("FAIL haz_wb: got we=%b a=%0d want 1 5", bus.write_enable, bus.write_addr);
    end
    bus.issue_valid = 1; bus.issue_addr = 5; bus.chk_addr1 = 5;
    tick();
    bus.issue_valid = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if ({bus.busy[5], bus.hazard} !== 2'b11) begin
        n_err++; $display("FAIL haz_set[%0d]: busy5/hazard got %b want 11", c, {bus.busy[5], bus.hazard});
      end
      tick();
    end
    bus.id_valid = 1; bus.id_addr = 5; bus.id_value = 32'h66;
    tick();
    bus.id_valid = 0;
    tick();
    n_cmp++;
    if ({bus.write_enable, bus.write_addr, bus.write_data_sel, bus.write_value_id, bus.hazard}
        !== {1'b1, 3'd5, 1'b0, 32'h66, 1'b1}) begin
      n_err++; $display("FAIL haz_wb2: got we=%b a=%0d sel=%b id=%h hz=%b want 1 5 0 66 1",
                        bus.write_enable, bus.write_addr, bus.write_data_sel, bus.write_value_id, bus.hazard);
    end
    tick();
    #1;
    n_cmp++;
    if ({bus.busy[5], bus.hazard} !== 2'b00) begin
      n_err++; $display("FAIL haz_clear: busy5/hazard got %b want 00", {bus.busy[5], bus.hazard});
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      bus.alu_valid = 1; bus.alu_addr = 3'(c); bus.alu_value = $urandom;
      bus.id_valid = 1; bus.id_addr = 3'(c + 4); bus.id_value = $urandom;
      bus.issue_valid = 1; bus.issue_addr = 3'(6 - c);
      tick();
    end
    idle_inputs();
    rst_n = 0;
    model_reset();
    #1;
    n_cmp++;
    if ({bus.write_enable, bus.busy, bus.alu_ready, bus.id_ready} !== {1'b0, 8'd0, 2'b11}) begin
      n_err++; $display("FAIL rstmid: we/busy/rdy got %b %h %b want 0 00 11",
                        bus.write_enable, bus.busy, {bus.alu_ready, bus.id_ready});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if ({bus.write_enable, bus.busy} !== 9'd0) begin
        n_err++; $display("FAIL rstmid_after[%0d]: we/busy got %b %h want 0 00", c, bus.write_enable, bus.busy);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.alu_valid   = ($urandom_range(0, 3) != 0);
      bus.alu_addr    = 3'($urandom);
      bus.alu_value   = $urandom;
      bus.id_valid    = ($urandom_range(0, 2) != 0);
      bus.id_addr     = 3'($urandom);
      bus.id_value    = $urandom;
      bus.issue_valid = $urandom_range(0, 1);
      bus.issue_addr  = 3'($urandom);
      bus.chk_addr1   = 3'($urandom);
      bus.chk_addr2   = 3'($urandom);
      #1;
      n_cmp++;
      if ({bus.alu_ready, bus.id_ready, bus.hazard}
          !== {exp_alu_rdy(), exp_id_rdy(), m_busy[bus.chk_addr1] | m_busy[bus.chk_addr2]}) begin
        n_err++; $display("FAIL rnd_comb[%0d]: rdy/hz got %b want %b", c, {bus.alu_ready, bus.id_ready, bus.hazard},
                          {exp_alu_rdy(), exp_id_rdy(), m_busy[bus.chk_addr1] | m_busy[bus.chk_addr2]});
      end
      tick();
      n_cmp++;
      if ({bus.write_enable, bus.write_addr, bus.write_data_sel, bus.write_value_alu, bus.write_value_id, bus.busy}
          !== {m_we, m_waddr, m_sel, m_valu, m_vid, m_busy}) begin
        n_err++; $display("FAIL rnd_out[%0d]: got %b %0d %b %h %h %h want %b %0d %b %h %h %h", c,
                          bus.write_enable, bus.write_addr, bus.write_data_sel, bus.write_value_alu, bus.write_value_id,
                          bus.busy, m_we, m_waddr, m_sel, m_valu, m_vid, m_busy);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_dual();
    test_back_to_back();
    test_issue_hazard();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
